// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: double-buffered hex digits, programmable
// dwell per digit and an all-off guard gap between digits to suppress ghosting.
module seg7_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int IDX_W        = 2,
   parameter int DWELL_W      = 16,
   parameter int GUARD_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic [DWELL_W-1:0]    dwell,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [3:0]            wr_data,
   input  logic                  wr_blank,
   input  logic                  commit,
   output logic [3:0]            digit_bin,
   output logic [NUM_DIGITS-1:0] anode_n,
   output logic [IDX_W-1:0]      cur_idx,
   output logic                  frame_start,
   output logic                  commit_pending
);

   localparam int SEL_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
   localparam logic [DWELL_W-1:0] GUARD_LAST = DWELL_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
   localparam bit                 HAS_GUARD  = (GUARD_CYCLES > 0);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GUARD = 2'd1;
   localparam logic [1:0] ST_DRIVE = 2'd2;

   logic [1:0]            state_q, state_d;
   logic [IDX_W-1:0]      cur_idx_q, idx_d;
   logic [DWELL_W-1:0]    cnt_q, cnt_d;
   logic [DWELL_W-1:0]    dwell_q, dwell_d;
   logic                  pending_q, pending_d;
   logic [NUM_DIGITS-1:0] anode_n_q, anode_n_d;
   logic [3:0]            digit_bin_q, digit_bin_d;
   logic                  frame_start_q;
   logic                  boundary;
   logic                  copy;

   logic [3:0]            shadow_val_q [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] shadow_blank_q;
   logic [3:0]            disp_val_q   [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] disp_blank_q;
   logic [3:0]            disp_val_nx  [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] disp_blank_nx;

   always_comb begin
      state_d  = state_q;
      idx_d    = cur_idx_q;
      cnt_d    = cnt_q;
      dwell_d  = dwell_q;
      boundary = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
         idx_d   = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               boundary = 1'b1;
               idx_d    = '0;
               cnt_d    = '0;
               if (HAS_GUARD) begin
                  state_d = ST_GUARD;
               end else begin
                  state_d = ST_DRIVE;
                  dwell_d = dwell;
               end
            end
            ST_GUARD: begin
               if (cnt_q == GUARD_LAST) begin
                  state_d = ST_DRIVE;
                  cnt_d   = '0;
                  dwell_d = dwell;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            ST_DRIVE: begin
               if (cnt_q == dwell_q) begin
                  idx_d    = (cur_idx_q == LAST_IDX) ? '0 : cur_idx_q + 1'b1;
                  boundary = (cur_idx_q == LAST_IDX);
                  cnt_d    = '0;
                  if (HAS_GUARD) begin
                     state_d = ST_GUARD;
                  end else begin
                     state_d = ST_DRIVE;
                     dwell_d = dwell;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
               idx_d   = '0;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // A commit raised on the copy edge survives to the following frame.
   assign copy      = boundary & pending_q;
   assign pending_d = commit | (pending_q & ~boundary);

   // Outputs are computed from the post-copy display so a new frame starts clean.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign disp_val_nx[gi]   = copy ? shadow_val_q[gi]   : disp_val_q[gi];
         assign disp_blank_nx[gi] = copy ? shadow_blank_q[gi] : disp_blank_q[gi];
         assign anode_n_d[gi]     = ~((state_d == ST_DRIVE) && (idx_d == IDX_W'(gi)) &&
                                      !disp_blank_nx[gi]);
      end
   endgenerate

   assign digit_bin_d = (state_d == ST_IDLE) ? 4'h0 : disp_val_nx[idx_d[SEL_W-1:0]];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            shadow_val_q[i] <= 4'h0;
            disp_val_q[i]   <= 4'h0;
         end
         shadow_blank_q <= '1;
         disp_blank_q   <= '1;
      end else begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (copy) begin
               disp_val_q[i]   <= shadow_val_q[i];
               disp_blank_q[i] <= shadow_blank_q[i];
            end
            if (wr_en && (wr_idx == IDX_W'(i))) begin
               shadow_val_q[i]   <= wr_data;
               shadow_blank_q[i] <= wr_blank;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         cur_idx_q     <= '0;
         cnt_q         <= '0;
         dwell_q       <= '0;
         pending_q     <= 1'b0;
         anode_n_q     <= '1;
         digit_bin_q   <= 4'h0;
         frame_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cur_idx_q     <= idx_d;
         cnt_q         <= cnt_d;
         dwell_q       <= dwell_d;
         pending_q     <= pending_d;
         anode_n_q     <= anode_n_d;
         digit_bin_q   <= digit_bin_d;
         frame_start_q <= boundary;
      end
   end

   assign digit_bin      = digit_bin_q;
   assign anode_n        = anode_n_q;
   assign cur_idx        = cur_idx_q;
   assign frame_start    = frame_start_q;
   assign commit_pending = pending_q;

endmodule
